// File: rtl/pipe_fwd_hazard_unit.sv
// pipe_fwd_hazard_unit: operand forwarding select and load-use interlock for the ID stage.
//  Keeps a shadow pipeline of destination tags for stages 1..DEPTH after ID (1=EXE)
//  and, per ID source operand, selects the youngest in-flight producer.
//  Ports:
//   clock, resetn         rising-edge clock, asynchronous active-low reset
//   id_valid              ID holds a real instruction
//   id_src, id_src_used   source register numbers (src i at [i*RA_W +: RA_W]) and read flags
//   id_dst, id_wreg       destination register and register-write flag of the ID instruction
//   id_m2reg              ID instruction is a load
//   flush                 kill the ID instruction; outranks stall
//   fwd_sel               per src: 0 = regfile, k = forward from stage k
//   fwd_mem               per src: take stage-k memory data instead of the ALU result
//   stall                 hold PC and IF/ID, bubble into EXE
//  Optional: define PIPE_FWD_PERF_EN to add perf_stall_cnt / perf_fwd_cnt counters.
module pipe_fwd_hazard_unit #(
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int RA_W     = 5,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     id_valid,
  input  logic [NUM_SRC*RA_W-1:0]  id_src,
  input  logic [NUM_SRC-1:0]       id_src_used,
  input  logic [RA_W-1:0]          id_dst,
  input  logic                     id_wreg,
  input  logic                     id_m2reg,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic [NUM_SRC-1:0]       fwd_mem,
  output logic                     stall
`ifdef PIPE_FWD_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_fwd_cnt
`endif
);
  logic [DEPTH:1] v, wreg, load;
  logic [RA_W-1:0] dst [1:DEPTH];
  logic [NUM_SRC-1:0] not_ready;
  logic advance;
  assign advance = id_valid & ~stall & ~flush;
  // Bubbles only clear v; the other fields are don't-care while v=0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v    <= '0;
      wreg <= '0;
      load <= '0;
      for (int k = 1; k <= DEPTH; k++) dst[k] <= '0;
    end else begin
      v    <= {v[DEPTH-1:1], advance};
      wreg <= {wreg[DEPTH-1:1], id_wreg};
      load <= {load[DEPTH-1:1], id_m2reg};
      dst[1] <= id_dst;
      for (int k = 2; k <= DEPTH; k++) dst[k] <= dst[k-1];
    end
  end
  // Scan oldest to youngest so the youngest match overwrites everything older.
  always_comb begin
    fwd_sel   = '0;
    fwd_mem   = '0;
    not_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (id_src_used[i] && v[k] && wreg[k] && dst[k] != '0 && dst[k] == id_src[i*RA_W +: RA_W]) begin
          not_ready[i]              = load[k] && k <= LOAD_LAT;
          fwd_sel[i*SEL_W +: SEL_W] = not_ready[i] ? '0 : SEL_W'(k);
          fwd_mem[i]                = load[k] && k > LOAD_LAT;
        end
      end
    end
  end
  assign stall = id_valid & ~flush & |not_ready;
`ifdef PIPE_FWD_PERF_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (advance && |fwd_sel) perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_fwd_hazard_unit.sv
// tb_pipe_fwd_hazard_unit: scoreboard bench driving a LOAD_LAT=1 and a LOAD_LAT=2 unit with shared stimulus.
module tb_pipe_fwd_hazard_unit;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic id_valid = 1'b0;
  logic [9:0] id_src = '0;
  logic [1:0] id_src_used = '0;
  logic [4:0] id_dst = '0;
  logic id_wreg = 1'b0;
  logic id_m2reg = 1'b0;
  logic flush = 1'b0;
  logic [3:0] sel1, sel2;
  logic [1:0] mem1, mem2;
  logic stall1, stall2;
  logic [6:0] o1, o2;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {
    string tag;
    logic [6:0] e1;
    logic [6:0] e2;
  } exp_t;
  exp_t q[$];
  localparam logic [6:0] Z = 7'd0;
`ifdef PIPE_FWD_PERF_EN
  logic [31:0] ps1, pf1, ps2, pf2;
`endif
  always #5 clock = ~clock;
  pipe_fwd_hazard_unit #(.NUM_SRC(2), .DEPTH(3), .LOAD_LAT(1), .RA_W(5)) dut1 (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .flush(flush), .fwd_sel(sel1), .fwd_mem(mem1), .stall(stall1)
`ifdef PIPE_FWD_PERF_EN
    , .perf_stall_cnt(ps1), .perf_fwd_cnt(pf1)
`endif
  );
  pipe_fwd_hazard_unit #(.NUM_SRC(2), .DEPTH(3), .LOAD_LAT(2), .RA_W(5)) dut2 (
    .clock(clock), .resetn(resetn), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .flush(flush), .fwd_sel(sel2), .fwd_mem(mem2), .stall(stall2)
`ifdef PIPE_FWD_PERF_EN
    , .perf_stall_cnt(ps2), .perf_fwd_cnt(pf2)
`endif
  );
  assign o1 = {stall1, mem1, sel1};
  assign o2 = {stall2, mem2, sel2};
  function automatic logic [6:0] ex(input bit st, input logic [1:0] s0, s1, input bit m0, m1);
    return {st, m1, m0, s1, s0};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step(input string tag, input bit rn, input bit v, input logic [4:0] s0, s1,
                      input logic [1:0] used, input logic [4:0] d, input bit w, ld, fl,
                      input logic [6:0] e1, e2);
    resetn = rn;
    id_valid = v;
    id_src = {s1, s0};
    id_src_used = used;
    id_dst = d;
    id_wreg = w;
    id_m2reg = ld;
    flush = fl;
    q.push_back('{tag, e1, e2});
    @(posedge clock);
    #1;
  endtask
  task automatic drain();
    repeat (3) step("nop", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, Z, Z);
  endtask
  always @(negedge clock) begin : mon
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({e.tag, "/lat1"}, 32'(o1), 32'(e.e1));
      chk({e.tag, "/lat2"}, 32'(o2), 32'(e.e2));
    end
  end
  initial begin
    @(posedge clock);
    #1;
    repeat (4) step("rst", 0, 1'($urandom), 5'($urandom), 5'($urandom), 2'($urandom), 5'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), Z, Z);
    step("idle", 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, Z, Z);
    step("alu_p", 1, 1, 1, 2, 2'b00, 3, 1, 0, 0, Z, Z);
    step("alu_k1", 1, 1, 3, 0, 2'b01, 4, 0, 0, 0, ex(0, 1, 0, 0, 0), ex(0, 1, 0, 0, 0));
    step("alu_k2", 1, 1, 0, 3, 2'b10, 4, 0, 0, 0, ex(0, 0, 2, 0, 0), ex(0, 0, 2, 0, 0));
    drain();
    step("lw5", 1, 1, 0, 0, 2'b00, 5, 1, 1, 0, Z, Z);
    step("lu_b", 1, 1, 5, 0, 2'b01, 6, 0, 0, 0, ex(1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0));
    step("lu_c", 1, 1, 5, 0, 2'b01, 6, 0, 0, 0, ex(0, 2, 0, 1, 0), ex(1, 0, 0, 0, 0));
`ifdef PIPE_FWD_PERF_EN
    chk("perf_stall_lat1", ps1, 32'd1);
    chk("perf_fwd_lat1", pf1, 32'd3);
    chk("perf_stall_lat2", ps2, 32'd2);
    chk("perf_fwd_lat2", pf2, 32'd2);
`endif
    step("lu_d", 1, 1, 5, 0, 2'b01, 6, 0, 0, 0, ex(0, 3, 0, 1, 0), ex(0, 3, 0, 1, 0));
    drain();
    step("r7a", 1, 1, 0, 0, 2'b00, 7, 1, 0, 0, Z, Z);
    step("r7b", 1, 1, 0, 0, 2'b00, 7, 1, 0, 0, Z, Z);
    step("young", 1, 1, 7, 0, 2'b01, 0, 1, 0, 0, ex(0, 1, 0, 0, 0), ex(0, 1, 0, 0, 0));
    step("r0", 1, 1, 0, 7, 2'b11, 0, 0, 0, 0, ex(0, 0, 2, 0, 0), ex(0, 0, 2, 0, 0));
    drain();
    step("lw8", 1, 1, 0, 0, 2'b00, 8, 1, 1, 0, Z, Z);
    step("add8", 1, 1, 0, 0, 2'b00, 8, 1, 0, 0, Z, Z);
    step("alu_over_ld", 1, 1, 8, 0, 2'b01, 0, 0, 0, 0, ex(0, 1, 0, 0, 0), ex(0, 1, 0, 0, 0));
    drain();
    step("add9", 1, 1, 0, 0, 2'b00, 9, 1, 0, 0, Z, Z);
    step("lw9", 1, 1, 0, 0, 2'b00, 9, 1, 1, 0, Z, Z);
    step("ld_over_alu_b", 1, 1, 9, 0, 2'b01, 0, 0, 0, 0, ex(1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0));
    step("ld_over_alu_c", 1, 1, 9, 0, 2'b01, 0, 0, 0, 0, ex(0, 2, 0, 1, 0), ex(1, 0, 0, 0, 0));
    drain();
    step("lw5f", 1, 1, 0, 0, 2'b00, 5, 1, 1, 0, Z, Z);
    step("flush", 1, 1, 5, 0, 2'b01, 10, 1, 0, 1, Z, Z);
    step("fl_bubble", 1, 1, 10, 0, 2'b01, 0, 0, 0, 0, Z, Z);
    drain();
    step("add13", 1, 1, 0, 0, 2'b00, 13, 1, 0, 0, Z, Z);
    step("lw12", 1, 1, 0, 0, 2'b00, 12, 1, 1, 0, Z, Z);
    step("no_valid", 1, 0, 12, 13, 2'b11, 0, 0, 0, 0, ex(0, 0, 2, 0, 0), ex(0, 0, 2, 0, 0));
    drain();
    step("add11", 1, 1, 0, 0, 2'b00, 11, 1, 0, 0, Z, Z);
    step("mid_rst", 0, 1, 11, 0, 2'b01, 0, 0, 0, 0, Z, Z);
`ifdef PIPE_FWD_PERF_EN
    chk("perf_stall_rst", ps1, 32'd0);
    chk("perf_fwd_rst", pf1, 32'd0);
`endif
    step("rst_rel", 1, 1, 11, 0, 2'b01, 0, 0, 0, 0, Z, Z);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
